// File: rtl/fpu_arb_pkg.sv
// ============================================================
// fpu_arb_pkg : shared defaults, tag type and round-robin helper
// Rev 1.0
// ============================================================
`default_nettype none

package fpu_arb_pkg;

    localparam int C_NREQ_DEF   = 4;
    localparam int C_LAT_DEF    = 24;
    localparam int C_MAXOUT_DEF = 4;
    // Wide enough for the largest supported requester count (8)
    localparam int C_IDX_W      = 3;

    typedef struct packed {
        logic               valid;
        logic [C_IDX_W-1:0] idx;
    } tag_t;

    // Requester index holding priority slot k when the pointer is at ptr
    function automatic int unsigned rr_slot(input int unsigned ptr,
                                            input int unsigned k,
                                            input int unsigned n);
        return (ptr + k) % n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_addsub_arbiter_rr.sv
// ============================================================
// rr_arbiter : NREQ-wide round-robin arbiter with pointer update
// Rev 1.0
// ============================================================
`default_nettype none

module rr_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NREQ = C_NREQ_DEF,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] elig,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_slot;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_slot    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_slot = IW'(rr_slot(32'(r_ptr), k, NREQ));
            if (!grant_any && elig[w_slot]) begin
                grant[w_slot] = 1'b1;
                grant_idx     = w_slot;
                grant_any     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (grant_any) begin
            r_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_addsub_arbiter.sv
// ============================================================
// fpu_addsub_arbiter : shares one pipelined fpu_addsub between
// NREQ requesters with round-robin issue, tag return and credits
// Rev 1.0
// ============================================================
`default_nettype none

module fpu_addsub_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NREQ   = C_NREQ_DEF,
    parameter int LAT    = C_LAT_DEF,
    parameter int MAXOUT = C_MAXOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_op,
    input  logic [2*NREQ-1:0]  req_rmode,
    input  logic [64*NREQ-1:0] req_opa,
    input  logic [64*NREQ-1:0] req_opb,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [63:0]        rsp_data,
    output logic               fpu_rst,
    output logic               fpu_enable,
    output logic               fpu_op,
    output logic [1:0]         fpu_rmode,
    output logic [63:0]        fpu_opa,
    output logic [63:0]        fpu_opb,
    input  logic [63:0]        fpu_out,
    output logic               busy
);

    localparam int C_IW = $clog2(NREQ);
    localparam int C_CW = $clog2(MAXOUT + 1);

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_grant;
    logic [C_IW-1:0] w_gidx;
    logic            w_gany;
    logic            w_accept;
    logic            w_op;
    logic [1:0]      w_rmode;
    logic [63:0]     w_opa;
    logic [63:0]     w_opb;
    tag_t            w_new_tag;
    tag_t            r_iss;
    tag_t            r_tag [LAT];
    logic            r_en;
    logic            w_pipe_busy;
    logic            w_rsp_fire;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (C_IW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .elig      (w_elig),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .grant_any (w_gany)
    );

    assign req_ready = rst ? w_grant : '0;
    assign w_accept  = rst & w_gany;

    always_comb begin
        w_op    = 1'b0;
        w_rmode = '0;
        w_opa   = '0;
        w_opb   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_op    = req_op[i];
                w_rmode = req_rmode[2*i +: 2];
                w_opa   = req_opa[64*i +: 64];
                w_opb   = req_opb[64*i +: 64];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fpu_op    <= 1'b0;
            fpu_rmode <= '0;
            fpu_opa   <= '0;
            fpu_opb   <= '0;
        end else if (w_accept) begin
            fpu_op    <= w_op;
            fpu_rmode <= w_rmode;
            fpu_opa   <= w_opa;
            fpu_opb   <= w_opb;
        end
    end

    assign w_new_tag.valid = w_accept;
    assign w_new_tag.idx   = C_IDX_W'(w_gidx);

    // The issue tag sits beside the operand registers; the LAT-stage pipe
    // then shifts in lockstep with the engine so the last stage lines up with fpu_out.
    always_comb begin
        w_pipe_busy = r_iss.valid;
        for (int s = 0; s < LAT - 1; s++) begin
            w_pipe_busy = w_pipe_busy | r_tag[s].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_iss <= '0;
            r_en  <= 1'b0;
            for (int s = 0; s < LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_iss <= w_new_tag;
            r_en  <= w_accept | w_pipe_busy | (|req_valid);
            if (r_en) begin
                r_tag[0] <= r_iss;
                for (int s = 1; s < LAT; s++) begin
                    r_tag[s] <= r_tag[s-1];
                end
            end
        end
    end

    assign w_rsp_fire = rst & r_en & r_tag[LAT-1].valid;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = w_rsp_fire && (r_tag[LAT-1].idx == C_IDX_W'(i));
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_credit
            logic [C_CW-1:0] r_cnt;

            assign w_elig[gi] = req_valid[gi] && (r_cnt < C_CW'(MAXOUT));

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_cnt <= '0;
                end else if (req_ready[gi] && !rsp_valid[gi]) begin
                    r_cnt <= r_cnt + C_CW'(1);
                end else if (!req_ready[gi] && rsp_valid[gi]) begin
                    r_cnt <= r_cnt - C_CW'(1);
                end
            end
        end
    endgenerate

    assign rsp_data   = fpu_out;
    assign fpu_rst    = ~rst;
    assign fpu_enable = r_en;
    assign busy       = rst & (w_pipe_busy | r_tag[LAT-1].valid | (|req_valid));

endmodule

`default_nettype wire
